mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have parameter PC_REG, default 4'd15, meaning the Rd index treated as the program counter.
REQ-002 SHALL have port clk, input, 1, system clock; one clock, all state updates on rising edge.
REQ-003 SHALL have port reset_n, input, 1, reset that is synchronous and active-low.
REQ-004 SHALL have inputs Cond 4, Op 2, Funct 6 and Rd 4, taken from the instruction register.
REQ-005 SHALL have input ALUFlags 4, carrying {N,Z,C,V} from the ALU in the current cycle.
REQ-006 SHALL have outputs PCWrite, MemWrite, RegWrite, IRWrite and AdrSrc, each 1 bit.
REQ-007 SHALL have 2-bit outputs ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc and ALUControl; ALUControl codes: 00 add, 01 sub, 10 and, 11 or.

Function
REQ-008 SHALL implement states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB and BRANCH.
REQ-009 SHALL transition FETCH->DECODE unconditionally.
REQ-010 SHALL leave DECODE by Op: 00 with Funct[5]=0 ->EXECUTER; 00 with Funct[5]=1 ->EXECUTEI; 01 ->MEMADR; 10 ->BRANCH; 11 ->FETCH with no write enables asserted.
REQ-011 SHALL go MEMADR->MEMRD if Funct[0]=1, else MEMADR->MEMWR.
REQ-012 SHALL sequence MEMRD->MEMWB->FETCH, MEMWR->FETCH, EXECUTER/EXECUTEI->ALUWB->FETCH and BRANCH->FETCH.
REQ-013 SHALL drive per-state controls as follows (unlisted controls 0):
- FETCH: AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, IRWrite=1, NextPC=1.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
- MEMADR: ALUSrcB=01.
- MEMRD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegW=1.
- MEMWR: AdrSrc=1, MemW=1.
- EXECUTER: ALUOp=1.
- EXECUTEI: ALUSrcB=01, ALUOp=1.
- ALUWB: RegW=1.
- BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, Branch=1.
REQ-014 SHALL decode the ALU as follows:
- ALUOp=0: ALUControl=00, FlagW=00.
- ALUOp=1, Funct[4:1]: 0100->00, 0010->01, 0000->10, 1100->11, 1010 (CMP)->01 with RegW suppressed; any other->00.
REQ-015 SHALL set FlagW[1]=Funct[0] and FlagW[0]=Funct[0] AND ALUControl in {00,01}, only when ALUOp=1.
REQ-016 SHALL drive ImmSrc=Op, RegSrc[0]=(Op==10) and RegSrc[1]=(Op==01), combinationally.
REQ-017 SHALL compute PCS = Branch OR (RegW AND Rd==PC_REG).
REQ-018 SHALL hold a flag register split into NZ and CV halves.
- At the clock edge, NZ<=ALUFlags[3:2] if FlagW[1]&CondEx; CV<=ALUFlags[1:0] if FlagW[0]&CondEx.
REQ-019 SHALL evaluate CondEx combinationally from Cond and the registered flags, per ARM EQ..LE plus AL=1110; Cond=1111 SHALL give CondEx=0.
REQ-020 SHALL register CondEx into CondExQ every cycle.
- PCWrite = NextPC OR (PCS AND CondExQ).
- RegWrite = RegW AND CondExQ.
- MemWrite = MemW AND CondExQ.
- A flag update in EXECUTE SHALL NOT affect the write decision in the following ALUWB.
REQ-021 SHALL hold latencies of: branch 3 cycles, data-processing 4, STR 4, LDR 5.

Reset
REQ-022 SHALL, on a clock edge with reset_n=0, load state=FETCH, flags=0000 and CondExQ=0, including mid-instruction.
REQ-023 SHALL force PCWrite, MemWrite, RegWrite and IRWrite to 0 while reset_n=0.
REQ-024 SHALL, in the first cycle after reset release, present FETCH outputs (IRWrite=1, PCWrite=1).

Structure
REQ-025 SHALL place the state enum, ALUControl codes and condition codes in shared package arm_mc_pkg.
REQ-026 SHALL implement the flag register, CondEx and CondExQ in sub-module cond_logic; FSM and decoders stay in mc_controller.

Verification
REQ-027 SHALL cover ADD R1,R2,R3 (Cond=1110, Op=00, Funct=001000): FETCH,DECODE,EXECUTER,ALUWB; RegWrite=1 in ALUWB only; ALUControl=00.
REQ-028 SHALL cover SUBS with ALUFlags=0100 followed by BEQ: Z=1 latched; BRANCH cycle PCWrite=1. With ALUFlags=0000 instead: PCWrite=0 in BRANCH.
REQ-029 SHALL cover CMP (Funct=010101) then ADDNE in the same sequence: CMP RegWrite=0 and flags updated; ADDNE with Z=1 gives RegWrite=0 in ALUWB.
REQ-030 SHALL cover LDR (Op=01, Funct[0]=1): path MEMADR,MEMRD,MEMWB; AdrSrc=1 in MEMRD; RegWrite=1 in MEMWB; 5 cycles total.
REQ-031 SHALL cover STR with Cond=1111: MemWrite=0 in MEMWR, then FETCH.
REQ-032 SHALL cover reset_n=0 asserted during MEMWR: no MemWrite at that edge; state=FETCH and flags=0000 next cycle.

Source files
------------

// File: rtl/arm_mc_pkg.sv
// -----------------------------------------------------------------------------
// arm_mc_pkg
// Shared definitions for the multicycle ARM controller:
//   - state_e  : main FSM states
//   - ALU_*    : ALUControl encodings (00 add, 01 sub, 10 and, 11 or)
//   - cond_e   : ARM condition field encodings
//   - OP_*/CMD_*: instruction Op field and data-processing cmd encodings
//   - ctrl_t   : raw per-state control bundle produced by the FSM
//   - cond_eval: condition check against {N,Z,C,V}
// -----------------------------------------------------------------------------
package arm_mc_pkg;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMRD    = 4'd3,
      MEMWB    = 4'd4,
      MEMWR    = 4'd5,
      EXECUTER = 4'd6,
      EXECUTEI = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9
   } state_e;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   typedef enum logic [3:0] {
      COND_EQ = 4'b0000,
      COND_NE = 4'b0001,
      COND_CS = 4'b0010,
      COND_CC = 4'b0011,
      COND_MI = 4'b0100,
      COND_PL = 4'b0101,
      COND_VS = 4'b0110,
      COND_VC = 4'b0111,
      COND_HI = 4'b1000,
      COND_LS = 4'b1001,
      COND_GE = 4'b1010,
      COND_LT = 4'b1011,
      COND_GT = 4'b1100,
      COND_LE = 4'b1101,
      COND_AL = 4'b1110,
      COND_NV = 4'b1111
   } cond_e;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   // Raw controls before condition gating.
   typedef struct packed {
      logic       next_pc;
      logic       branch;
      logic       reg_w;
      logic       mem_w;
      logic       ir_write;
      logic       adr_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] result_src;
      logic       alu_op;
   } ctrl_t;

   // flags = {N,Z,C,V}
   function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
      logic n, z, c, v;
      logic res;
      {n, z, c, v} = flags;
      case (cond)
         COND_EQ: res = z;
         COND_NE: res = ~z;
         COND_CS: res = c;
         COND_CC: res = ~c;
         COND_MI: res = n;
         COND_PL: res = ~n;
         COND_VS: res = v;
         COND_VC: res = ~v;
         COND_HI: res = c & ~z;
         COND_LS: res = ~c | z;
         COND_GE: res = (n == v);
         COND_LT: res = (n != v);
         COND_GT: res = ~z & (n == v);
         COND_LE: res = z | (n != v);
         COND_AL: res = 1'b1;
         default: res = 1'b0;  // NV: never executes
      endcase
      return res;
   endfunction

endpackage

// File: rtl/cond_logic.sv
// -----------------------------------------------------------------------------
// cond_logic
// Holds the NZ/CV flag register, evaluates the instruction condition against
// the registered flags and registers that result once per cycle.
// Ports:
//   clk          - system clock
//   reset_n      - synchronous active-low reset (flags and cond_ex_q cleared)
//   cond_i       - instruction condition field
//   alu_flags_i  - {N,Z,C,V} from the ALU this cycle
//   flag_w_i     - [1] enables NZ update, [0] enables CV update
//   cond_ex_q_o  - condition result registered from the previous cycle
// -----------------------------------------------------------------------------
module cond_logic
   import arm_mc_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] cond_i,
   input  logic [3:0] alu_flags_i,
   input  logic [1:0] flag_w_i,
   output logic       cond_ex_q_o
);

   logic [1:0] nz_q, nz_d;
   logic [1:0] cv_q, cv_d;
   logic       cond_ex;
   logic       cond_ex_q;

   assign cond_ex = cond_eval(cond_i, {nz_q, cv_q});

   // A flag write is itself conditional: a failed condition leaves flags alone.
   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      nz_d = nz_q;
      cv_d = cv_q;
      if (flag_w_i[1] && cond_ex) nz_d = alu_flags_i[3:2];
      if (flag_w_i[0] && cond_ex) cv_d = alu_flags_i[1:0];
   end

   always_ff @(posedge clk) begin
      // NOTE: state uses non-blocking assignments so all registers update from
      // pre-edge values; reset is sampled on the edge like any other input.
      if (!reset_n) begin
         nz_q      <= 2'b00;
         cv_q      <= 2'b00;
         cond_ex_q <= 1'b0;
      end else begin
         nz_q      <= nz_d;
         cv_q      <= cv_d;
         // Registered from pre-update flags, so a flag write in EXECUTE cannot
         // change the write decision taken in the following ALUWB.
         cond_ex_q <= cond_ex;
      end
   end

   assign cond_ex_q_o = cond_ex_q;

endmodule

// File: rtl/mc_controller.sv
// -----------------------------------------------------------------------------
// mc_controller
// Multicycle ARM control unit: main FSM, ALU decoder, immediate/register source
// decode, PC-write logic, plus the cond_logic flag/condition block.
// Ports:
//   clk, reset_n            - clock, synchronous active-low reset
//   Cond, Op, Funct, Rd      - instruction register fields
//   ALUFlags                 - {N,Z,C,V} from the ALU this cycle
//   PCWrite, MemWrite,
//   RegWrite, IRWrite        - write enables (forced low while reset_n=0)
//   AdrSrc                   - memory address select
//   ALUSrcA, ALUSrcB         - ALU operand selects
//   ResultSrc                - result bus select
//   ImmSrc, RegSrc           - immediate extend / register-read selects
//   ALUControl               - 00 add, 01 sub, 10 and, 11 or
// -----------------------------------------------------------------------------
module mc_controller
   import arm_mc_pkg::*;
#(
   parameter logic [3:0] PC_REG = 4'd15
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] Cond,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic [3:0] Rd,
   input  logic [3:0] ALUFlags,
   output logic       PCWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic       IRWrite,
   output logic       AdrSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic [1:0] ImmSrc,
   output logic [1:0] RegSrc,
   output logic [1:0] ALUControl
);

   state_e     state_q, state_d;
   ctrl_t      ctrl;
   logic [1:0] alu_control;
   logic [1:0] flag_w;
   logic       no_write;
   logic       reg_w;
   logic       pcs;
   logic       cond_ex_q;

   // ---------------------------------------------------------------- FSM ----
   always_ff @(posedge clk) begin
      if (!reset_n) state_q <= FETCH;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH:  state_d = DECODE;
         DECODE: begin
            case (Op)
               OP_DP:   state_d = Funct[5] ? EXECUTEI : EXECUTER;
               OP_MEM:  state_d = MEMADR;
               OP_BR:   state_d = BRANCH;
               default: state_d = FETCH;  // undefined Op: drop back, no writes
            endcase
         end
         MEMADR:   state_d = Funct[0] ? MEMRD : MEMWR;
         MEMRD:    state_d = MEMWB;
         MEMWB:    state_d = FETCH;
         MEMWR:    state_d = FETCH;
         EXECUTER: state_d = ALUWB;
         EXECUTEI: state_d = ALUWB;
         ALUWB:    state_d = FETCH;
         BRANCH:   state_d = FETCH;
         default:  state_d = FETCH;
      endcase
   end

   always_comb begin
      ctrl = '0;
      case (state_q)
         FETCH: begin
            ctrl.adr_src    = 1'b0;
            ctrl.alu_src_a  = 2'b01;
            ctrl.alu_src_b  = 2'b10;
            ctrl.result_src = 2'b10;
            ctrl.ir_write   = 1'b1;
            ctrl.next_pc    = 1'b1;
         end
         DECODE: begin
            ctrl.alu_src_a  = 2'b01;
            ctrl.alu_src_b  = 2'b10;
            ctrl.result_src = 2'b10;
         end
         MEMADR: ctrl.alu_src_b = 2'b01;
         MEMRD:  ctrl.adr_src   = 1'b1;
         MEMWB: begin
            ctrl.result_src = 2'b01;
            ctrl.reg_w      = 1'b1;
         end
         MEMWR: begin
            ctrl.adr_src = 1'b1;
            ctrl.mem_w   = 1'b1;
         end
         EXECUTER: ctrl.alu_op = 1'b1;
         EXECUTEI: begin
            ctrl.alu_src_b = 2'b01;
            ctrl.alu_op    = 1'b1;
         end
         ALUWB: ctrl.reg_w = 1'b1;
         BRANCH: begin
            ctrl.alu_src_a  = 2'b10;
            ctrl.alu_src_b  = 2'b01;
            ctrl.result_src = 2'b10;
            ctrl.branch     = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

   // -------------------------------------------------------- ALU decode ----
   always_comb begin
      alu_control = ALU_ADD;
      flag_w      = 2'b00;
      if (ctrl.alu_op) begin
         case (Funct[4:1])
            CMD_ADD: alu_control = ALU_ADD;
            CMD_SUB: alu_control = ALU_SUB;
            CMD_AND: alu_control = ALU_AND;
            CMD_ORR: alu_control = ALU_ORR;
            CMD_CMP: alu_control = ALU_SUB;
            default: alu_control = ALU_ADD;
         endcase
         // C and V are only meaningful for arithmetic results.
         flag_w[1] = Funct[0];
         flag_w[0] = Funct[0] & ((alu_control == ALU_ADD) || (alu_control == ALU_SUB));
      end
   end

   // CMP suppression is decoded straight from the instruction fields rather
   // than gated by ALUOp, because the register write happens in ALUWB where
   // ALUOp is already low; the fields stay stable for the whole instruction.
   assign no_write = (Op == OP_DP) && (Funct[4:1] == CMD_CMP);
   assign reg_w    = ctrl.reg_w & ~no_write;
   assign pcs      = ctrl.branch | (reg_w & (Rd == PC_REG));

   // ------------------------------------------------------ cond / flags ----
   cond_logic u_cond_logic (
      .clk         (clk),
      .reset_n     (reset_n),
      .cond_i      (Cond),
      .alu_flags_i (ALUFlags),
      .flag_w_i    (flag_w),
      .cond_ex_q_o (cond_ex_q)
   );

   // ----------------------------------------------------------- outputs ----
   // Enables are masked by reset_n so nothing is written during a reset cycle.
   assign PCWrite    = reset_n & (ctrl.next_pc | (pcs & cond_ex_q));
   assign RegWrite   = reset_n & reg_w & cond_ex_q;
   assign MemWrite   = reset_n & ctrl.mem_w & cond_ex_q;
   assign IRWrite    = reset_n & ctrl.ir_write;
   assign AdrSrc     = ctrl.adr_src;
   assign ALUSrcA    = ctrl.alu_src_a;
   assign ALUSrcB    = ctrl.alu_src_b;
   assign ResultSrc  = ctrl.result_src;
   assign ALUControl = alu_control;
   assign ImmSrc     = Op;
   assign RegSrc     = {(Op == OP_MEM), (Op == OP_BR)};

endmodule

// File: tb/tb_mc_controller.sv
// -----------------------------------------------------------------------------
// tb_mc_controller
// Directed instruction sequences through mc_controller. Each cycle's outputs
// are packed as {PCWrite,MemWrite,RegWrite,IRWrite,AdrSrc,ALUSrcA,ALUSrcB,
// ResultSrc,ALUControl} and compared against hand-derived vectors.
// -----------------------------------------------------------------------------
module tb_mc_controller;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] Cond;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic [3:0] Rd;
   logic [3:0] ALUFlags;
   logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
   logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;

   int n_cmp  = 0;
   int n_fail = 0;

   localparam logic [12:0] OBS_F  = 13'b1_0_0_1_0_01_10_10_00;
   localparam logic [12:0] OBS_D  = 13'b0_0_0_0_0_01_10_10_00;
   localparam logic [12:0] OBS_0  = 13'b0_0_0_0_0_00_00_00_00;

   logic [12:0] obs_log [8];
   logic [3:0]  aux_log [8];

   mc_controller #(.PC_REG(4'd15)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .Cond       (Cond),
      .Op         (Op),
      .Funct      (Funct),
      .Rd         (Rd),
      .ALUFlags   (ALUFlags),
      .PCWrite    (PCWrite),
      .MemWrite   (MemWrite),
      .RegWrite   (RegWrite),
      .IRWrite    (IRWrite),
      .AdrSrc     (AdrSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ResultSrc  (ResultSrc),
      .ImmSrc     (ImmSrc),
      .RegSrc     (RegSrc),
      .ALUControl (ALUControl)
   );

   always #5 clk = ~clk;

   function automatic logic [12:0] sample_obs();
      return {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc,
              ALUSrcA, ALUSrcB, ResultSrc, ALUControl};
   endfunction

   // Drives one instruction from its FETCH cycle for n cycles, logging the
   // outputs of each cycle plus the first cycle after it (no advance past it).
   task automatic exec_instr(input logic [3:0] c, input logic [1:0] o,
                             input logic [5:0] f, input logic [3:0] r,
                             input logic [3:0] fl, input int n);
      Cond = c; Op = o; Funct = f; Rd = r; ALUFlags = fl;
      for (int i = 0; i < n; i++) begin
         #1;
         obs_log[i] = sample_obs();
         aux_log[i] = {ImmSrc, RegSrc};
         @(negedge clk);
      end
      #1;
      obs_log[n] = sample_obs();
      aux_log[n] = {ImmSrc, RegSrc};
   endtask

   task automatic test_reset();
      reset_n = 1'b0; Cond = 4'hE; Op = 2'b00; Funct = 6'h00; Rd = 4'h0; ALUFlags = 4'h0;
      repeat (2) @(negedge clk);
      #1;
      n_cmp++;
      if ({PCWrite, MemWrite, RegWrite, IRWrite} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_enables: got %b expected 0000", {PCWrite, MemWrite, RegWrite, IRWrite});
      end
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      n_cmp++;
      if (sample_obs() !== OBS_F) begin
         n_fail++;
         $display("FAIL reset_first_fetch: got %b expected %b", sample_obs(), OBS_F);
      end
      n_cmp++;
      if ({dut.u_cond_logic.nz_q, dut.u_cond_logic.cv_q} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b expected 0000", {dut.u_cond_logic.nz_q, dut.u_cond_logic.cv_q});
      end
   endtask

   task automatic test_add();
      logic [12:0] exp_v [8];
      exp_v = '{OBS_F, OBS_D, OBS_0, 13'b0_0_1_0_0_00_00_00_00, OBS_F, OBS_0, OBS_0, OBS_0};
      exec_instr(4'b1110, 2'b00, 6'b001000, 4'd1, 4'b0000, 4);
      for (int i = 0; i <= 4; i++) begin
         n_cmp++;
         if (obs_log[i] !== exp_v[i]) begin
            n_fail++;
            $display("FAIL add cycle %0d: got %b expected %b", i, obs_log[i], exp_v[i]);
         end
      end
      n_cmp++;
      if (aux_log[1] !== 4'b0000) begin
         n_fail++;
         $display("FAIL add_immsrc_regsrc: got %b expected 0000", aux_log[1]);
      end
   endtask

   task automatic test_subs_beq(input logic [3:0] fl, input logic taken);
      logic [12:0] exp_v [8];
      logic [12:0] br_v;
      exp_v = '{OBS_F, OBS_D, 13'b0_0_0_0_0_00_00_00_01, 13'b0_0_1_0_0_00_00_00_00,
                OBS_F, OBS_0, OBS_0, OBS_0};
      exec_instr(4'b1110, 2'b00, 6'b000101, 4'd1, fl, 4);
      for (int i = 0; i <= 4; i++) begin
         n_cmp++;
         if (obs_log[i] !== exp_v[i]) begin
            n_fail++;
            $display("FAIL subs(taken=%0b) cycle %0d: got %b expected %b", taken, i, obs_log[i], exp_v[i]);
         end
      end
      n_cmp++;
      if ({dut.u_cond_logic.nz_q, dut.u_cond_logic.cv_q} !== fl) begin
         n_fail++;
         $display("FAIL subs_flags: got %b expected %b", {dut.u_cond_logic.nz_q, dut.u_cond_logic.cv_q}, fl);
      end
      br_v  = taken ? 13'b1_0_0_0_0_10_01_10_00 : 13'b0_0_0_0_0_10_01_10_00;
      exp_v = '{OBS_F, OBS_D, br_v, OBS_F, OBS_0, OBS_0, OBS_0, OBS_0};
      exec_instr(4'b0000, 2'b10, 6'b100000, 4'd0, 4'b0000, 3);
      for (int i = 0; i <= 3; i++) begin
         n_cmp++;
         if (obs_log[i] !== exp_v[i]) begin
            n_fail++;
            $display("FAIL beq(taken=%0b) cycle %0d: got %b expected %b", taken, i, obs_log[i], exp_v[i]);
         end
      end
      n_cmp++;
      if (aux_log[2] !== 4'b1001) begin
         n_fail++;
         $display("FAIL beq_immsrc_regsrc: got %b expected 1001", aux_log[2]);
      end
   endtask

   // ADDS NE with Z=0: condition passes in EXECUTE and sets Z; the ALUWB write
   // must still happen because it uses the condition from before the update.
   task automatic test_flag_snapshot();
      logic [12:0] exp_v [8];
      exp_v = '{OBS_F, OBS_D, OBS_0, 13'b0_0_1_0_0_00_00_00_00, OBS_F, OBS_0, OBS_0, OBS_0};
      exec_instr(4'b0001, 2'b00, 6'b001001, 4'd4, 4'b0100, 4);
      for (int i = 0; i <= 4; i++) begin
         n_cmp++;
         if (obs_log[i] !== exp_v[i]) begin
            n_fail++;
            $display("FAIL addsne cycle %0d: got %b expected %b", i, obs_log[i], exp_v[i]);
         end
      end
      n_cmp++;
      if ({dut.u_cond_logic.nz_q, dut.u_cond_logic.cv_q} !== 4'b0100) begin
         n_fail++;
         $display("FAIL addsne_flags: got %b expected 0100", {dut.u_cond_logic.nz_q, dut.u_cond_logic.cv_q});
      end
   endtask

   task automatic test_cmp_addne();
      logic [12:0] exp_v [8];
      exp_v = '{OBS_F, OBS_D, 13'b0_0_0_0_0_00_00_00_01, OBS_0, OBS_F, OBS_0, OBS_0, OBS_0};
      exec_instr(4'b1110, 2'b00, 6'b010101, 4'd0, 4'b0110, 4);
      for (int i = 0; i <= 4; i++) begin
         n_cmp++;
         if (obs_log[i] !== exp_v[i]) begin
            n_fail++;
            $display("FAIL cmp cycle %0d: got %b expected %b", i, obs_log[i], exp_v[i]);
         end
      end
      n_cmp++;
      if ({dut.u_cond_logic.nz_q, dut.u_cond_logic.cv_q} !== 4'b0110) begin
         n_fail++;
         $display("FAIL cmp_flags: got %b expected 0110", {dut.u_cond_logic.nz_q, dut.u_cond_logic.cv_q});
      end
      exp_v = '{OBS_F, OBS_D, OBS_0, OBS_0, OBS_F, OBS_0, OBS_0, OBS_0};
      exec_instr(4'b0001, 2'b00, 6'b001000, 4'd2, 4'b0000, 4);
      for (int i = 0; i <= 4; i++) begin
         n_cmp++;
         if (obs_log[i] !== exp_v[i]) begin
            n_fail++;
            $display("FAIL addne cycle %0d: got %b expected %b", i, obs_log[i], exp_v[i]);
         end
      end
   endtask

   task automatic test_pc_dest();
      logic [12:0] exp_v [8];
      exp_v = '{OBS_F, OBS_D, OBS_0, 13'b1_0_1_0_0_00_00_00_00, OBS_F, OBS_0, OBS_0, OBS_0};
      exec_instr(4'b1110, 2'b00, 6'b001000, 4'd15, 4'b0000, 4);
      for (int i = 0; i <= 4; i++) begin
         n_cmp++;
         if (obs_log[i] !== exp_v[i]) begin
            n_fail++;
            $display("FAIL add_pc cycle %0d: got %b expected %b", i, obs_log[i], exp_v[i]);
         end
      end
   endtask

   task automatic test_ldr();
      logic [12:0] exp_v [8];
      exp_v = '{OBS_F, OBS_D, 13'b0_0_0_0_0_00_01_00_00, 13'b0_0_0_0_1_00_00_00_00,
                13'b0_0_1_0_0_00_00_01_00, OBS_F, OBS_0, OBS_0};
      exec_instr(4'b1110, 2'b01, 6'b011001, 4'd3, 4'b0000, 5);
      for (int i = 0; i <= 5; i++) begin
         n_cmp++;
         if (obs_log[i] !== exp_v[i]) begin
            n_fail++;
            $display("FAIL ldr cycle %0d: got %b expected %b", i, obs_log[i], exp_v[i]);
         end
      end
      n_cmp++;
      if (aux_log[1] !== 4'b0110) begin
         n_fail++;
         $display("FAIL ldr_immsrc_regsrc: got %b expected 0110", aux_log[1]);
      end
   endtask

   task automatic test_str_nv();
      logic [12:0] exp_v [8];
      exp_v = '{OBS_F, OBS_D, 13'b0_0_0_0_0_00_01_00_00, 13'b0_0_0_0_1_00_00_00_00,
                OBS_F, OBS_0, OBS_0, OBS_0};
      exec_instr(4'b1111, 2'b01, 6'b011000, 4'd3, 4'b0000, 4);
      for (int i = 0; i <= 4; i++) begin
         n_cmp++;
         if (obs_log[i] !== exp_v[i]) begin
            n_fail++;
            $display("FAIL str_nv cycle %0d: got %b expected %b", i, obs_log[i], exp_v[i]);
         end
      end
   endtask

   // STR AL runs up to MEMWR (MemWrite=1), then reset is asserted mid-cycle.
   task automatic test_reset_mid_memwr();
      exec_instr(4'b1110, 2'b01, 6'b011000, 4'd3, 4'b0000, 3);
      n_cmp++;
      if (obs_log[3] !== 13'b0_1_0_0_1_00_00_00_00) begin
         n_fail++;
         $display("FAIL str_memwr: got %b expected 0100100000000", obs_log[3]);
      end
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if ({PCWrite, MemWrite, RegWrite, IRWrite} !== 4'b0000) begin
         n_fail++;
         $display("FAIL midreset_enables: got %b expected 0000", {PCWrite, MemWrite, RegWrite, IRWrite});
      end
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      n_cmp++;
      if (sample_obs() !== OBS_F) begin
         n_fail++;
         $display("FAIL midreset_fetch: got %b expected %b", sample_obs(), OBS_F);
      end
      n_cmp++;
      if ({dut.u_cond_logic.nz_q, dut.u_cond_logic.cv_q} !== 4'b0000) begin
         n_fail++;
         $display("FAIL midreset_flags: got %b expected 0000", {dut.u_cond_logic.nz_q, dut.u_cond_logic.cv_q});
      end
   endtask

   task automatic test_undef_op();
      logic [12:0] exp_v [8];
      exp_v = '{OBS_F, OBS_D, OBS_F, OBS_0, OBS_0, OBS_0, OBS_0, OBS_0};
      exec_instr(4'b1110, 2'b11, 6'b000000, 4'd15, 4'b0000, 2);
      for (int i = 0; i <= 2; i++) begin
         n_cmp++;
         if (obs_log[i] !== exp_v[i]) begin
            n_fail++;
            $display("FAIL undef_op cycle %0d: got %b expected %b", i, obs_log[i], exp_v[i]);
         end
      end
      n_cmp++;
      if (aux_log[1] !== 4'b1100) begin
         n_fail++;
         $display("FAIL undef_immsrc_regsrc: got %b expected 1100", aux_log[1]);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_subs_beq(4'b0100, 1'b1);
      test_subs_beq(4'b0000, 1'b0);
      test_flag_snapshot();
      test_cmp_addne();
      test_pc_dest();
      test_ldr();
      test_str_nv();
      test_reset_mid_memwr();
      test_undef_op();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
